// File: rtl/dtack_pkg.sv
// rtl/dtack_pkg.sv - shared encodings and helpers for the /DTACK responder
package dtack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } dtack_state_t;

  localparam int DTACK_CNT_W  = 4;
  localparam int DTACK_WS_MAX = 15;

  // Lowest-numbered set bit wins when several chip selects overlap.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dtack_responder_if.sv
// rtl/dtack_responder_if.sv - 68000 slave-side bus signals seen by the responder
interface dtack_responder_if #(
  parameter int NSLOTS = 4
);
  logic              n_as;
  logic [NSLOTS-1:0] sel;
  logic [NSLOTS-1:0] ext_rdy;
  logic              bus_timeout;
  logic              n_dtack;
  logic [1:0]        ack_slot;
  logic              busy;
  logic              aborted;

  modport master (
    output n_as, sel, ext_rdy, bus_timeout,
    input  n_dtack, ack_slot, busy, aborted
  );

  modport slave (
    input  n_as, sel, ext_rdy, bus_timeout,
    output n_dtack, ack_slot, busy, aborted
  );
endinterface

// File: rtl/dtack_responder_ws_counter.sv
// rtl/dtack_responder_ws_counter.sv - loadable wait-state down-counter that sticks at zero
module ws_counter
  import dtack_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DTACK_CNT_W-1:0] load_val,
  input  logic                   dec,
  output logic [DTACK_CNT_W-1:0] cnt,
  output logic                   zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dtack_responder.sv
// rtl/dtack_responder.sv - terminates /AS cycles with /DTACK after per-slot wait states,
// optional device ready, and abort on bus timeout
module dtack_responder
  import dtack_pkg::*;
#(
  parameter int unsigned NSLOTS   = 4,
  parameter int unsigned WS0      = 0,
  parameter int unsigned WS1      = 0,
  parameter int unsigned WS2      = 0,
  parameter int unsigned WS3      = 0,
  parameter logic [3:0]  RDY_MASK = 4'b0000
) (
  input logic               clk,
  input logic               reset,
  dtack_responder_if.slave  bus
);

  if (NSLOTS < 1 || NSLOTS > 4) begin : g_bad_nslots
    $error("dtack_responder: NSLOTS must be 1..4");
  end
  if (WS0 > DTACK_WS_MAX || WS1 > DTACK_WS_MAX ||
      WS2 > DTACK_WS_MAX || WS3 > DTACK_WS_MAX) begin : g_bad_ws
    $error("dtack_responder: wait states must be 0..15");
  end
  if ((RDY_MASK >> NSLOTS) != 4'b0000) begin : g_bad_mask
    $error("dtack_responder: RDY_MASK has bits beyond NSLOTS");
  end

  dtack_state_t           state_q, state_d;
  logic [1:0]             ack_slot_q;
  logic                   n_dtack_q;
  logic                   aborted_q;

  logic [3:0]             sel_w;
  logic [3:0]             rdy_w;
  logic [3:0]             mask_w;
  logic [1:0]             slot_next;
  logic [DTACK_CNT_W-1:0] ws_load;
  logic [DTACK_CNT_W-1:0] cnt;
  logic                   cnt_zero;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic                   abort_now;
  logic                   rdy_ok;
  logic                   busy;

  // Pad the slot vectors so the slot index can always address four bits.
  always_comb begin
    sel_w               = 4'b0000;
    rdy_w               = 4'b0000;
    sel_w[NSLOTS-1:0]   = bus.sel;
    rdy_w[NSLOTS-1:0]   = bus.ext_rdy;
    mask_w              = RDY_MASK;
    slot_next           = lowest_set(sel_w);
    rdy_ok              = !mask_w[ack_slot_q] || rdy_w[ack_slot_q];
    case (slot_next)
      2'd0:    ws_load = 4'(WS0);
      2'd1:    ws_load = 4'(WS1);
      2'd2:    ws_load = 4'(WS2);
      default: ws_load = 4'(WS3);
    endcase
  end

  ws_counter u_ws_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (ws_load),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      n_dtack_q  <= 1'b1;
      ack_slot_q <= 2'd0;
      aborted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_dtack_q <= (state_d != ACK);
      aborted_q <= abort_now;
      if (cnt_load) ack_slot_q <= slot_next;
    end
  end

  // Within WAIT: strobe release beats timeout, timeout beats acknowledge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!bus.n_as && (sel_w != 4'b0000)) state_d = WAIT;
      WAIT: begin
        if (bus.n_as)                  state_d = IDLE;
        else if (bus.bus_timeout)      state_d = HOLD;
        else if (cnt_zero && rdy_ok)   state_d = ACK;
      end
      ACK:  if (bus.n_as) state_d = IDLE;
      HOLD: if (bus.n_as) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    cnt_load  = (state_q == IDLE) && !bus.n_as && (sel_w != 4'b0000);
    cnt_dec   = (state_q == WAIT) && !bus.n_as && !bus.bus_timeout;
    abort_now = (state_q == WAIT) && !bus.n_as && bus.bus_timeout;
  end

  assign bus.n_dtack  = n_dtack_q;
  assign bus.ack_slot = ack_slot_q;
  assign bus.busy     = busy;
  assign bus.aborted  = aborted_q;

endmodule

// File: tb/tb_dtack_responder.sv
// tb/tb_dtack_responder.sv - directed self-checking bench for dtack_responder
module tb_dtack_responder;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dtack_responder_if #(.NSLOTS(4)) bus ();

  dtack_responder #(
    .NSLOTS   (4),
    .WS0      (0),
    .WS1      (2),
    .WS2      (5),
    .WS3      (15),
    .RDY_MASK (4'b0010)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.n_as        = 1'b1;
    bus.sel         = 4'b0000;
    bus.ext_rdy     = 4'b0000;
    bus.bus_timeout = 1'b0;
    step();
    step();
    chk("rst_n_dtack", bus.n_dtack, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack_slot", bus.ack_slot, 0);
    chk("rst_aborted", bus.aborted, 0);
    reset = 1'b0;
    step();

    // slot 0, zero wait states
    bus.n_as = 1'b0; bus.sel = 4'b0001;
    step();
    chk("t1_e0_busy", bus.busy, 1);
    chk("t1_e0_n_dtack", bus.n_dtack, 1);
    step();
    chk("t1_e1_n_dtack", bus.n_dtack, 0);
    chk("t1_e1_ack_slot", bus.ack_slot, 0);
    step();
    chk("t1_e2_n_dtack", bus.n_dtack, 0);
    bus.n_as = 1'b1; bus.sel = 4'b0000;
    step();
    chk("t1_e3_n_dtack", bus.n_dtack, 1);
    chk("t1_e3_busy", bus.busy, 0);

    // slot 2, five wait states
    bus.n_as = 1'b0; bus.sel = 4'b0100;
    step();
    chk("t2_e0_busy", bus.busy, 1);
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("t2_wait_n_dtack", bus.n_dtack, 1);
      chk("t2_wait_busy", bus.busy, 1);
    end
    step();
    chk("t2_e6_n_dtack", bus.n_dtack, 0);
    chk("t2_e6_ack_slot", bus.ack_slot, 2);
    bus.n_as = 1'b1; bus.sel = 4'b0000;
    step();
    chk("t2_neg_n_dtack", bus.n_dtack, 1);
    chk("t2_neg_busy", bus.busy, 0);

    // slot 1 with ready wait
    bus.n_as = 1'b0; bus.sel = 4'b0010;
    step();
    for (int e = 1; e <= 9; e++) begin
      step();
      chk("t3_rdywait_n_dtack", bus.n_dtack, 1);
    end
    bus.ext_rdy = 4'b0010;
    step();
    chk("t3_e10_n_dtack", bus.n_dtack, 0);
    chk("t3_e10_ack_slot", bus.ack_slot, 1);
    bus.n_as = 1'b1; bus.sel = 4'b0000; bus.ext_rdy = 4'b0000;
    step();
    chk("t3_neg_n_dtack", bus.n_dtack, 1);

    // slot 3, timeout at E8
    bus.n_as = 1'b0; bus.sel = 4'b1000;
    for (int e = 0; e <= 7; e++) step();
    bus.bus_timeout = 1'b1;
    step();
    chk("t4_e8_aborted", bus.aborted, 1);
    chk("t4_e8_n_dtack", bus.n_dtack, 1);
    chk("t4_e8_busy", bus.busy, 1);
    bus.bus_timeout = 1'b0;
    step();
    chk("t4_e9_aborted", bus.aborted, 0);
    chk("t4_e9_busy", bus.busy, 1);
    step();
    chk("t4_hold_n_dtack", bus.n_dtack, 1);
    bus.n_as = 1'b1; bus.sel = 4'b0000;
    step();
    chk("t4_idle_busy", bus.busy, 0);
    chk("t4_idle_aborted", bus.aborted, 0);

    // timeout coinciding with cnt=0 and ready
    bus.n_as = 1'b0; bus.sel = 4'b0001;
    step();
    bus.bus_timeout = 1'b1;
    step();
    chk("t4b_aborted", bus.aborted, 1);
    chk("t4b_n_dtack", bus.n_dtack, 1);
    bus.bus_timeout = 1'b0;
    step();
    chk("t4b_hold_n_dtack", bus.n_dtack, 1);
    chk("t4b_hold_aborted", bus.aborted, 0);
    bus.n_as = 1'b1; bus.sel = 4'b0000;
    step();
    chk("t4b_idle_busy", bus.busy, 0);

    // strobe release and timeout on the same edge
    bus.n_as = 1'b0; bus.sel = 4'b1000;
    step();
    step();
    bus.n_as = 1'b1; bus.sel = 4'b0000; bus.bus_timeout = 1'b1;
    step();
    chk("t4c_busy", bus.busy, 0);
    chk("t4c_aborted", bus.aborted, 0);
    bus.bus_timeout = 1'b0;
    step();

    // overlapping selects, latched slot ignores later sel changes
    bus.n_as = 1'b0; bus.sel = 4'b0110; bus.ext_rdy = 4'b0010;
    step();
    chk("t5_ack_slot", bus.ack_slot, 1);
    bus.sel = 4'b0001;
    step();
    chk("t5_e1_n_dtack", bus.n_dtack, 1);
    step();
    chk("t5_e2_n_dtack", bus.n_dtack, 1);
    step();
    chk("t5_e3_n_dtack", bus.n_dtack, 0);
    chk("t5_e3_ack_slot", bus.ack_slot, 1);
    bus.n_as = 1'b1; bus.sel = 4'b0000; bus.ext_rdy = 4'b0000;
    step();

    // strobe dropped mid-WAIT
    bus.n_as = 1'b0; bus.sel = 4'b0100;
    step();
    step();
    step();
    bus.n_as = 1'b1; bus.sel = 4'b0000;
    step();
    chk("t5_drop_busy", bus.busy, 0);
    chk("t5_drop_n_dtack", bus.n_dtack, 1);
    step();
    chk("t5_drop_after_n_dtack", bus.n_dtack, 1);

    // unclaimed cycle
    bus.n_as = 1'b0; bus.sel = 4'b0000;
    for (int e = 0; e < 20; e++) begin
      step();
      chk("t5_nosel_busy", bus.busy, 0);
      chk("t5_nosel_n_dtack", bus.n_dtack, 1);
    end
    bus.n_as = 1'b1;
    step();

    // reset while in ACK
    bus.n_as = 1'b0; bus.sel = 4'b0100;
    for (int e = 0; e <= 6; e++) step();
    chk("t6_pre_n_dtack", bus.n_dtack, 0);
    chk("t6_pre_ack_slot", bus.ack_slot, 2);
    reset = 1'b1; bus.n_as = 1'b1; bus.sel = 4'b0000;
    step();
    chk("t6_rst_n_dtack", bus.n_dtack, 1);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_ack_slot", bus.ack_slot, 0);
    reset = 1'b0;

    // back-to-back cycles
    bus.n_as = 1'b0; bus.sel = 4'b0001;
    step();
    step();
    chk("t6_c1_n_dtack", bus.n_dtack, 0);
    bus.n_as = 1'b1; bus.sel = 4'b0000;
    step();
    chk("t6_c1_neg_n_dtack", bus.n_dtack, 1);
    chk("t6_c1_neg_busy", bus.busy, 0);
    bus.n_as = 1'b0; bus.sel = 4'b0001;
    step();
    chk("t6_c2_e0_busy", bus.busy, 1);
    chk("t6_c2_e0_n_dtack", bus.n_dtack, 1);
    step();
    chk("t6_c2_e1_n_dtack", bus.n_dtack, 0);
    chk("t6_c2_e1_ack_slot", bus.ack_slot, 0);
    bus.n_as = 1'b1; bus.sel = 4'b0000;
    step();
    chk("t6_c2_neg_n_dtack", bus.n_dtack, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dtack_responder.md
Name: dtack_responder

Overview:
- Slave-side responder for the 68000 bus: terminates an asserted /AS cycle by asserting /DTACK after a per-slot, parameterised number of wait states.
- Optionally waits for a per-slot external ready line before asserting /DTACK.
- Sits beside the bus timer. If the bus timer's timeout fires first, the responder aborts and never asserts /DTACK, leaving BERR generation to the bus-error logic.
- One instance serves up to four decoded device slots.

Parameters:
- NSLOTS, 4, number of chip-select slots; fixed range 1..4.
- WS0, 0, wait states for slot 0; range 0..15.
- WS1, 0, wait states for slot 1; range 0..15.
- WS2, 0, wait states for slot 2; range 0..15.
- WS3, 0, wait states for slot 3; range 0..15.
- RDY_MASK, 4'b0000, bit i set means slot i also requires ext_rdy[i] before /DTACK.

Ports:
- clk  in  1  CPU clock.
- reset  in  1  synchronous reset, active-high.
- n_as  in  1  address strobe, active-low, already synchronous to clk.
- sel  in  NSLOTS  decoded chip selects, active-high, qualified externally by address only.
- ext_rdy  in  NSLOTS  per-slot device ready, active-high; ignored for slots whose RDY_MASK bit is clear.
- bus_timeout  in  1  bus timer timeout level.
- n_dtack  out  1  registered /DTACK, active-low.
- ack_slot  out  2  index of the slot being serviced, registered.
- busy  out  1  high whenever state is not IDLE.
- aborted  out  1  one-clock pulse when a cycle is abandoned due to bus_timeout.

Behaviour:
- Reset (sampled at posedge clk while reset=1) forces: state=IDLE, cnt=0, n_dtack=1, ack_slot=0, aborted=0. Reset overrides all other events, including mid-ACK.
- Wait-state counter: cnt is 4 bits, down-counting, with no wrap (it holds at 0). Any WSn above 15 or RDY_MASK wider than NSLOTS is an elaboration error.
- State IDLE:
  - If n_as=0 and any sel bit is 1: latch slot = lowest-numbered set bit, ack_slot<=slot, cnt<=WS[slot], go to WAIT.
  - If n_as=0 and sel=0: stay in IDLE. A decode may arrive on a later cycle; an unclaimed cycle is left to the bus timer.
- State WAIT, evaluated in priority order:
  - (a) n_as=1: go to IDLE; /DTACK is never asserted.
  - (b) bus_timeout=1: go to HOLD, aborted<=1 for one clock.
  - (c) cnt!=0: cnt<=cnt-1.
  - (d) cnt=0 and (RDY_MASK[slot]=0 or ext_rdy[slot]=1): go to ACK, n_dtack<=0.
  - (e) Otherwise stay in WAIT.
- State ACK:
  - n_dtack stays 0.
  - On the first edge sampling n_as=1: n_dtack<=1, go to IDLE.
  - bus_timeout is ignored here; the acknowledge is already given.
- State HOLD:
  - n_dtack stays 1.
  - On the edge sampling n_as=1: go to IDLE.
- Latency: with the first edge E0 seeing n_as=0 and sel valid, n_dtack goes low after edge E(WS+1) when no ready wait applies. WS=0 therefore gives /DTACK one clock after the sample.
- Latching: changes on sel or ack_slot sources after the latch are ignored until IDLE.
- Back-to-back cycles: n_as going high then low on consecutive samples must start a fresh cycle. The ACK→IDLE transition takes one edge, and IDLE re-samples on the next edge.
- Simultaneous events:
  - cnt=0 with ready and bus_timeout on the same edge: the timeout wins (go to HOLD, no /DTACK).
  - n_as=1 with bus_timeout on the same edge: go to IDLE with no aborted pulse.
- busy is a combinational decode of the state register.

Decomposition:
- Shared package dtack_pkg holds:
  - state encodings IDLE=2'd0, WAIT=2'd1, ACK=2'd2, HOLD=2'd3;
  - DTACK_CNT_W=4;
  - DTACK_WS_MAX=15.
- Natural sub-module: ws_counter, a loadable 4-bit down-counter with hold-at-zero and a zero flag.
- The priority encoder and state machine stay in dtack_responder.

Test Plan:
1. WS0=0, n_as low with sel=4'b0001 at E0 -> n_dtack=0 after E1, ack_slot=0. n_as high sampled at E3 -> n_dtack=1 after E3, busy=0.
2. WS2=5, sel=4'b0100 -> n_dtack low exactly after E6; ack_slot=2; busy=1 from E0 through negation.
3. RDY_MASK=4'b0010, WS1=2, ext_rdy[1] held low until E9 -> n_dtack low after E10, not after E3.
4. WS3=15, bus_timeout pulsed at E8 -> aborted=1 for one clock, n_dtack stays 1, IDLE on the edge n_as is sampled high. Also cover bus_timeout coinciding with cnt=0 and ready -> still no /DTACK.
5. sel=4'b0110 -> ack_slot=1, WS1 delay used. n_as dropped mid-WAIT -> IDLE, no /DTACK. sel=0 with n_as low for 20 clocks -> no response, busy=0.
6. reset=1 asserted while in ACK -> next edge n_dtack=1, state IDLE, ack_slot=0. A back-to-back second cycle right after negation is acknowledged with correct latency.
